// File: rtl/acc_pkg.sv
// acc_pkg: shared types and constants for the acc add/sub datapath and its sequencer
package acc_pkg;
  localparam int ACC_W = 4;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} acc_state_t;
endpackage

// File: rtl/acc.sv
// acc: 4-bit combinational adder/subtractor (c=0 add, c=1 subtract)
module acc
  import acc_pkg::*;
(
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  input  logic             c,
  output logic [ACC_W-1:0] saida
);
  assign saida = c ? a - b : a + b;
endmodule

// File: rtl/acc_seq.sv
// acc_seq: valid/ready running-total unit around acc with carry/borrow and overflow flags.
// Define ACC_SAT_EN for saturating results; default build wraps modulo 2^W.
module acc_seq
  import acc_pkg::*;
#(
  parameter int W     = ACC_W,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [W-1:0]     operand,
  output logic [W-1:0]     acc_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             cb,
  output logic             ovf,
  output logic [CNT_W-1:0] op_count
);
  acc_state_t state;
  logic op_r;
  logic [W-1:0] opnd_r;
  logic [W-1:0] saida;
  logic [W-1:0] nxt;
  logic cb_n;
  logic ovf_n;
  acc u_acc (.a(acc_q), .b(opnd_r), .c(op_r), .saida(saida));
  // ovf: result sign departs from acc_q when add operands agree in sign or sub operands differ
  always_comb begin
    cb_n  = (op_r == OP_SUB) ? (opnd_r > acc_q)
                             : ({1'b0, acc_q} + {1'b0, opnd_r} > {1'b0, {W{1'b1}}});
    ovf_n = (saida[W-1] != acc_q[W-1]) && ((op_r == OP_ADD) == (acc_q[W-1] == opnd_r[W-1]));
`ifdef ACC_SAT_EN
    nxt   = cb_n ? ((op_r == OP_ADD) ? {W{1'b1}} : {W{1'b0}}) : saida;
`else
    nxt   = saida;
`endif
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      op_r      <= OP_ADD;
      opnd_r    <= '0;
      acc_q     <= '0;
      cb        <= 1'b0;
      ovf       <= 1'b0;
      op_count  <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else if (clr) begin
      state     <= IDLE;
      acc_q     <= '0;
      cb        <= 1'b0;
      ovf       <= 1'b0;
      op_count  <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_r     <= op;
          opnd_r   <= operand;
          in_ready <= 1'b0;
          state    <= EXEC;
        end
        EXEC: begin
          acc_q     <= nxt;
          cb        <= cb_n;
          ovf       <= ovf_n;
          out_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          op_count  <= op_count + CNT_W'(1);
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_acc_seq.sv
// tb_acc_seq: scoreboard bench for acc_seq; expected results queued at input handshake, checked on out_valid rise
module tb_acc_seq;
  logic clk = 0, reset = 1, clr = 0, in_valid = 0, op = 0, out_ready = 1;
  logic [3:0] operand = '0;
  logic in_ready, out_valid, cb, ovf;
  logic [3:0] acc_q, op_count;

  acc_seq dut (
    .clk(clk), .reset(reset), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .operand(operand), .acc_q(acc_q), .out_valid(out_valid),
    .out_ready(out_ready), .cb(cb), .ovf(ovf), .op_count(op_count)
  );

  always #5 clk = ~clk;

`ifdef ACC_SAT_EN
  localparam logic [3:0] E_WRAP = 4'd15, E_SUB4 = 4'd11, E_BP = 4'd2, E_CL = 4'd3;
  localparam logic       CB_SUB4 = 1'b0;
`else
  localparam logic [3:0] E_WRAP = 4'd3, E_SUB4 = 4'd15, E_BP = 4'd6, E_CL = 4'd7;
  localparam logic       CB_SUB4 = 1'b1;
`endif

  typedef struct {
    logic [3:0] a;
    logic       cb;
    logic       ovf;
    int         cyc;
  } exp_t;
  exp_t q[$];
  int cyc = 0, total = 0, passed = 0;
  logic prev_ov = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(posedge clk) begin
    exp_t e;
    cyc++;
    #1;
    if (out_valid && !prev_ov) begin
      if (q.size() == 0) chk("unexpected_out_valid", 1, 0);
      else begin
        e = q.pop_front();
        chk("result_acc", acc_q, e.a);
        chk("result_flags", {cb, ovf}, {e.cb, e.ovf});
        chk("latency", cyc, e.cyc + 1);
      end
    end
    prev_ov = out_valid;
  end

  task automatic do_op(input logic o, input logic [3:0] v, input logic [3:0] ea,
                       input logic ecb, input logic eovf);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    chk("in_ready_wait", in_ready, 1);
    op = o; operand = v; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    q.push_back('{ea, ecb, eovf, cyc});
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    chk("out_valid_wait", out_valid, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!(in_ready && !out_valid) && n < 50) begin @(negedge clk); n++; end
    chk("idle_wait", {in_ready, out_valid}, 2'b10);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("rst_acc", acc_q, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_op_count", op_count, 0);
    chk("rst_flags", {cb, ovf}, 2'b00);

    do_op(0, 4'd3, 4'd3, 0, 0);
    do_op(0, 4'd5, 4'd8, 0, 1);
    wait_idle();
    chk("chain_count", op_count, 2);

    do_op(0, 4'd4, 4'd12, 0, 0);
    do_op(0, 4'd7, E_WRAP, 1, 0);
    do_op(1, 4'd4, E_SUB4, CB_SUB4, 0);
    wait_idle();
    chk("wrap_count", op_count, 5);

    out_ready = 0;
    do_op(1, 4'd9, E_BP, 0, 0);
    wait_valid();
    repeat (5) begin
      @(negedge clk);
      in_valid = 1; op = 0; operand = 4'd1;
      chk("bp_valid", out_valid, 1);
      chk("bp_acc", acc_q, E_BP);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_flags", {cb, ovf}, 2'b00);
    end
    @(negedge clk);
    in_valid = 0; out_ready = 1;
    @(posedge clk); #1;
    chk("bp_count", op_count, 6);
    chk("bp_valid_drop", out_valid, 0);
    @(negedge clk);
    chk("bp_no_accept", {acc_q, in_ready}, {E_BP, 1'b1});

    out_ready = 0;
    do_op(0, 4'd1, E_CL, 0, 0);
    wait_valid();
    @(negedge clk);
    clr = 1; out_ready = 1;
    @(posedge clk); #1;
    clr = 0;
    chk("clr_acc", acc_q, 0);
    chk("clr_count", op_count, 0);
    chk("clr_state", {in_ready, out_valid}, 2'b10);
    chk("clr_flags", {cb, ovf}, 2'b00);

    do_op(0, 4'd6, 4'd6, 0, 0);
    wait_idle();
    chk("pre_rst_count", op_count, 1);
    op = 0; operand = 4'd5; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    chk("exec_in_ready", in_ready, 0);
    #2 reset = 1;
    #1;
    chk("async_acc", acc_q, 0);
    chk("async_count", op_count, 0);
    chk("async_state", {in_ready, out_valid}, 2'b10);
    repeat (2) @(negedge clk);
    reset = 0;
    repeat (3) @(negedge clk);
    chk("no_out_after_rst", {out_valid, acc_q}, 5'b0);

    for (int i = 0; i < 16; i++) begin
`ifdef ACC_SAT_EN
      do_op(0, 4'd1, (i == 15) ? 4'd15 : 4'(i + 1), i == 15, i == 7);
`else
      do_op(0, 4'd1, 4'(i + 1), i == 15, i == 7);
`endif
    end
    wait_idle();
    chk("count_wrap", op_count, 0);
    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
